// File: rtl/boss_health_ctl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : boss_health_ctl_pkg
//  Description : Shared game definitions for the boss health controller:
//                boss life-cycle state encoding, game_active codes and the
//                regeneration period (used only when BOSS_HP_REGEN_EN is
//                defined).
//  Revision    : 1.0 - initial release
// ============================================================================
package boss_health_ctl_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ALIVE  = 3'd1,
        INVULN = 3'd2,
        DYING  = 3'd3,
        DEAD   = 3'd4
    } boss_state_t;

    localparam logic [1:0] GAME_MENU = 2'b00;
    localparam logic [1:0] GAME_RUN  = 2'b01;

    // Frame ticks spent in ALIVE per regenerated hit point.
    localparam int REGEN_FRAMES = 120;

endpackage : boss_health_ctl_pkg
`default_nettype wire

// File: rtl/boss_health_ctl_frame_timer.sv
`default_nettype none
// ============================================================================
//  Module      : boss_frame_timer
//  Description : Loadable down-counter stepped by frame_tick. Shared by the
//                INVULN and DYING phases of the boss controller.
//  Ports       : clk, rst          - clock, synchronous active-high reset
//                frame_tick_i      - one-clk pulse per video frame
//                load_i/load_val_i - load a new count (wins over a tick)
//                freeze_i          - hold the count, ignore ticks
//                clear_i           - force count to zero (highest priority)
//                done_o            - combinational pulse: tick taken at count 1
//  Revision    : 1.0 - initial release
// ============================================================================
module boss_frame_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             frame_tick_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             freeze_i,
    input  logic             clear_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        done_o  = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (freeze_i) begin
            count_d = count_q;
        end else if (load_i) begin
            // A load coinciding with a tick keeps the freshly loaded value.
            count_d = load_val_i;
        end else if (frame_tick_i && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
            done_o  = (count_q == CNT_W'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule : boss_frame_timer
`default_nettype wire

// File: rtl/boss_health_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : boss_health_ctl
//  Description : Boss hit-point keeper at the receiving end of the weapon hit
//                path. Applies projectile/melee damage, runs invulnerability
//                and death timing, and reports alive/flash/dying/defeated.
//  Ports       : clk, rst           - clock, synchronous active-high reset
//                frame_tick_i       - one-clk pulse per video frame
//                game_active_i[1:0] - 00 menu, 01 run, 1x paused
//                projectile_hit_i   - weapon hit strobe
//                melee_hit_i        - melee hit strobe
//                boss_alive_o       - boss can take damage / collide
//                boss_hp_o          - current hit points
//                boss_hit_flash_o   - high while invulnerable after a hit
//                boss_dying_o       - high during death animation
//                boss_defeated_o    - one-clk pulse on death
//  Options     : BOSS_HP_REGEN_EN   - slow HP regeneration while ALIVE
//  Revision    : 1.0 - initial release
// ============================================================================
module boss_health_ctl
    import boss_health_ctl_pkg::*;
#(
    parameter int HP_W         = 8,
    parameter int BOSS_MAX_HP  = 100,
    parameter int PROJ_DMG     = 2,
    parameter int MELEE_DMG    = 5,
    parameter int IFRAMES      = 8,
    parameter int DEATH_FRAMES = 60
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            frame_tick_i,
    input  logic [1:0]      game_active_i,
    input  logic            projectile_hit_i,
    input  logic            melee_hit_i,
    output logic            boss_alive_o,
    output logic [HP_W-1:0] boss_hp_o,
    output logic            boss_hit_flash_o,
    output logic            boss_dying_o,
    output logic            boss_defeated_o
);

    localparam int TMR_MAX = (IFRAMES > DEATH_FRAMES) ? IFRAMES : DEATH_FRAMES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [HP_W-1:0] MAX_HP = HP_W'(BOSS_MAX_HP);

    boss_state_t     state_q, state_d;
    logic [HP_W-1:0] hp_q, hp_d;
    logic            proj_q, proj_d;
    logic            melee_q, melee_d;
    logic            alive_q, flash_q, dying_q, defeated_q;
    logic [HP_W:0]   dmg;

    logic             tmr_load;
    logic [TMR_W-1:0] tmr_val;
    logic             tmr_freeze;
    logic             tmr_clear;
    logic             tmr_done;

    wire w_run  = (game_active_i == GAME_RUN);
    wire w_menu = (game_active_i == GAME_MENU);

`ifdef BOSS_HP_REGEN_EN
    localparam int REGEN_W = $clog2(REGEN_FRAMES);
    logic [REGEN_W-1:0] regen_q, regen_d;
`endif

    boss_frame_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk          (clk),
        .rst          (rst),
        .frame_tick_i (frame_tick_i),
        .load_i       (tmr_load),
        .load_val_i   (tmr_val),
        .freeze_i     (tmr_freeze),
        .clear_i      (tmr_clear),
        .done_o       (tmr_done)
    );

    // Strobes are captured only while the boss is in ALIVE and the fight is
    // running; anything else is dropped rather than queued.
    assign proj_d  = projectile_hit_i && w_run && (state_q == ALIVE);
    assign melee_d = melee_hit_i      && w_run && (state_q == ALIVE);

    // Damage is summed one bit wider than HP so the compare never wraps.
    assign dmg = (proj_q  ? (HP_W+1)'(PROJ_DMG)  : '0)
               + (melee_q ? (HP_W+1)'(MELEE_DMG) : '0);

    always_comb begin
        state_d    = state_q;
        hp_d       = hp_q;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        tmr_freeze = 1'b0;
        tmr_clear  = 1'b0;
`ifdef BOSS_HP_REGEN_EN
        regen_d    = regen_q;
`endif
        if (w_menu) begin
            state_d   = IDLE;
            hp_d      = MAX_HP;
            tmr_clear = 1'b1;
`ifdef BOSS_HP_REGEN_EN
            regen_d   = '0;
`endif
        end else if (!w_run) begin
            tmr_freeze = 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = ALIVE;
                end
                ALIVE: begin
                    if (dmg >= {1'b0, hp_q}) begin
                        hp_d     = '0;
                        state_d  = DYING;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(DEATH_FRAMES);
                    end else if (dmg != '0) begin
                        hp_d     = hp_q - dmg[HP_W-1:0];
                        state_d  = INVULN;
                        tmr_load = 1'b1;
                        tmr_val  = TMR_W'(IFRAMES);
                    end
`ifdef BOSS_HP_REGEN_EN
                    if (dmg != '0) begin
                        regen_d = '0;
                    end else if (frame_tick_i) begin
                        if (regen_q == REGEN_W'(REGEN_FRAMES - 1)) begin
                            regen_d = '0;
                            if (hp_q < MAX_HP) begin
                                hp_d = hp_q + HP_W'(1);
                            end
                        end else begin
                            regen_d = regen_q + REGEN_W'(1);
                        end
                    end
`endif
                end
                INVULN: begin
                    if (tmr_done) begin
                        state_d = ALIVE;
                    end
                end
                DYING: begin
                    if (tmr_done) begin
                        state_d = DEAD;
                    end
                end
                DEAD: begin
                    hp_d = '0;
                end
                default: begin
                    state_d = IDLE;
                    hp_d    = MAX_HP;
                end
            endcase
`ifdef BOSS_HP_REGEN_EN
            if (state_q != ALIVE) begin
                regen_d = '0;
            end
`endif
        end
    end

    // Status flags are registered from the next state so they line up with
    // boss_hp_o on the same clock.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            hp_q       <= MAX_HP;
            proj_q     <= 1'b0;
            melee_q    <= 1'b0;
            alive_q    <= 1'b0;
            flash_q    <= 1'b0;
            dying_q    <= 1'b0;
            defeated_q <= 1'b0;
`ifdef BOSS_HP_REGEN_EN
            regen_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hp_q       <= hp_d;
            proj_q     <= proj_d;
            melee_q    <= melee_d;
            alive_q    <= (state_d == ALIVE) || (state_d == INVULN);
            flash_q    <= (state_d == INVULN);
            dying_q    <= (state_d == DYING);
            defeated_q <= (state_q == DYING) && (state_d == DEAD);
`ifdef BOSS_HP_REGEN_EN
            regen_q    <= regen_d;
`endif
        end
    end

    assign boss_alive_o     = alive_q;
    assign boss_hp_o        = hp_q;
    assign boss_hit_flash_o = flash_q;
    assign boss_dying_o     = dying_q;
    assign boss_defeated_o  = defeated_q;

endmodule : boss_health_ctl
`default_nettype wire

// File: tb/tb_boss_health_ctl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_boss_health_ctl
//  Description : Self-checking bench for boss_health_ctl. Expected output
//                snapshots are queued with each stimulus step and compared
//                when the DUT output is sampled.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_boss_health_ctl;

    localparam int HP_W = 8;

    logic            clk;
    logic            rst;
    logic            frame_tick;
    logic [1:0]      game_active;
    logic            projectile_hit;
    logic            melee_hit;
    logic            boss_alive;
    logic [HP_W-1:0] boss_hp;
    logic            boss_hit_flash;
    logic            boss_dying;
    logic            boss_defeated;

    int n_tests;
    int n_fail;

    typedef struct {
        string tag;
        int    hp;
        int    alive;
        int    flash;
        int    dying;
        int    defeated;
    } exp_t;

    exp_t exp_q[$];

    boss_health_ctl dut (
        .clk              (clk),
        .rst              (rst),
        .frame_tick_i     (frame_tick),
        .game_active_i    (game_active),
        .projectile_hit_i (projectile_hit),
        .melee_hit_i      (melee_hit),
        .boss_alive_o     (boss_alive),
        .boss_hp_o        (boss_hp),
        .boss_hit_flash_o (boss_hit_flash),
        .boss_dying_o     (boss_dying),
        .boss_defeated_o  (boss_defeated)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tb_check(input string tag, input int got, input int want);
        n_tests++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Queue the expected snapshot for the next sample point.
    task automatic expect_out(input string tag, input int hp, input int a,
                              input int f, input int d, input int x);
        exp_t e;
        e.tag = tag; e.hp = hp; e.alive = a; e.flash = f; e.dying = d; e.defeated = x;
        exp_q.push_back(e);
    endtask

    // Pop one expected snapshot and compare it to the DUT outputs now.
    task automatic score();
        exp_t e;
        if (exp_q.size() == 0) begin
            tb_check("sb_underflow", 1, 0);
        end else begin
            e = exp_q.pop_front();
            tb_check({e.tag, ".hp"},       int'(boss_hp),        e.hp);
            tb_check({e.tag, ".alive"},    int'(boss_alive),     e.alive);
            tb_check({e.tag, ".flash"},    int'(boss_hit_flash), e.flash);
            tb_check({e.tag, ".dying"},    int'(boss_dying),     e.dying);
            tb_check({e.tag, ".defeated"}, int'(boss_defeated),  e.defeated);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            step();
            frame_tick = 1'b0;
        end
    endtask

    // Strobe for one clk, then one more clk for the damage to land.
    task automatic hit(input logic p, input logic m);
        projectile_hit = p;
        melee_hit      = m;
        step();
        projectile_hit = 1'b0;
        melee_hit      = 1'b0;
        step();
    endtask

    initial begin
        n_tests        = 0;
        n_fail         = 0;
        rst            = 1'b1;
        frame_tick     = 1'b0;
        game_active    = 2'b00;
        projectile_hit = 1'b0;
        melee_hit      = 1'b0;

        // ---- reset state ----
        expect_out("reset", 100, 0, 0, 0, 0);
        step(); step();
        score();
        rst = 1'b0;

        // ---- 1: start fight, single projectile hit, iframes ----
        game_active = 2'b01;
        expect_out("start", 100, 1, 0, 0, 0);
        step();
        score();
        projectile_hit = 1'b1;
        expect_out("hit_lat1", 100, 1, 0, 0, 0);
        step();
        score();
        projectile_hit = 1'b0;
        expect_out("proj_hit", 98, 1, 1, 0, 0);
        step();
        score();
        expect_out("iframe7", 98, 1, 1, 0, 0);
        tick(7);
        score();
        expect_out("iframe8", 98, 1, 0, 0, 0);
        tick(1);
        score();

        // ---- 2: simultaneous hits, hit during INVULN dropped ----
        game_active = 2'b00;
        expect_out("menu1", 100, 0, 0, 0, 0);
        step();
        score();
        game_active = 2'b01;
        step();
        expect_out("dual_hit", 93, 1, 1, 0, 0);
        hit(1'b1, 1'b1);
        score();
        expect_out("invuln_hit", 93, 1, 1, 0, 0);
        hit(1'b1, 1'b0);
        score();

        // ---- 4: pause mid-INVULN with 5 ticks left ----
        tick(3);
        game_active = 2'b10;
        tick(20);
        hit(1'b1, 1'b0);
        hit(1'b0, 1'b1);
        hit(1'b1, 1'b1);
        expect_out("paused", 93, 1, 1, 0, 0);
        step();
        score();
        game_active = 2'b01;
        expect_out("resume4", 93, 1, 1, 0, 0);
        tick(4);
        score();
        expect_out("resume5", 93, 1, 0, 0, 0);
        tick(1);
        score();

        // ---- 3: drain to 3 HP, lethal melee, death timing ----
        for (int i = 0; i < 18; i++) begin
            hit(1'b0, 1'b1);
            tick(8);
        end
        expect_out("hp3", 3, 1, 0, 0, 0);
        step();
        score();
        expect_out("lethal", 0, 0, 0, 1, 0);
        hit(1'b0, 1'b1);
        score();
        expect_out("dying59", 0, 0, 0, 1, 0);
        tick(59);
        score();
        expect_out("defeat", 0, 0, 0, 0, 1);
        tick(1);
        score();
        expect_out("dead1", 0, 0, 0, 0, 0);
        step();
        score();
        hit(1'b1, 1'b1);
        tick(70);
        expect_out("dead_hold", 0, 0, 0, 0, 0);
        step();
        score();

        // ---- 5a: menu during DYING ----
        game_active = 2'b00;
        step();
        game_active = 2'b01;
        step();
        for (int i = 0; i < 14; i++) begin
            hit(1'b1, 1'b1);
            tick(8);
        end
        expect_out("hp2", 2, 1, 0, 0, 0);
        step();
        score();
        expect_out("exact_kill", 0, 0, 0, 1, 0);
        hit(1'b1, 1'b0);
        score();
        tick(10);
        game_active = 2'b00;
        frame_tick  = 1'b1;
        expect_out("menu_dying", 100, 0, 0, 0, 0);
        step();
        score();
        frame_tick = 1'b0;
        expect_out("menu_hold", 100, 0, 0, 0, 0);
        tick(80);
        score();

        // ---- 5b: rst mid-fight ----
        game_active = 2'b01;
        step();
        hit(1'b1, 1'b0);
        rst = 1'b1;
        expect_out("rst_mid", 100, 0, 0, 0, 0);
        step();
        score();
        rst = 1'b0;
        expect_out("after_rst", 100, 1, 0, 0, 0);
        step();
        score();

        // ---- 6: regeneration (or its absence) ----
        hit(1'b0, 1'b1);
        tick(8);
        hit(1'b0, 1'b1);
        tick(8);
`ifdef BOSS_HP_REGEN_EN
        expect_out("regen239", 91, 1, 0, 0, 0);
        tick(239);
        score();
        expect_out("regen240", 92, 1, 0, 0, 0);
        tick(1);
        score();
        game_active = 2'b00;
        step();
        game_active = 2'b01;
        step();
        expect_out("regen_sat", 100, 1, 0, 0, 0);
        tick(120);
        score();
`else
        expect_out("noregen", 90, 1, 0, 0, 0);
        tick(240);
        score();
`endif

        tb_check("sb_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_boss_health_ctl
`default_nettype wire
